// File: rtl/rr_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rr_sched_pkg
// Description : Shared types and default sizing for the round-robin grant
//               scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package rr_sched_pkg;

  localparam int unsigned c_NUM_PORTS_DEFAULT = 4;
  localparam int unsigned c_MAX_HOLD_DEFAULT  = 8;

  // Scheduler state: IDLE has no owner, BUSY has exactly one owner
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } sched_state_e;

endpackage
`default_nettype wire

// File: rtl/fixed_priority_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fixed_priority_arbiter
// Description : Combinational fixed-priority arbiter; the lowest-indexed
//               active request wins. Also reports the winner index and
//               whether any request is present.
// Revision    : 1.0 - initial release
// ============================================================================
module fixed_priority_arbiter #(
  parameter int unsigned NUM_PORTS = 4
) (
  input  logic [NUM_PORTS-1:0]         req_i,
  output logic [NUM_PORTS-1:0]         gnt_o,
  output logic [$clog2(NUM_PORTS)-1:0] id_o,
  output logic                         any_o
);

  localparam int unsigned ID_W = $clog2(NUM_PORTS);

  // Scan from the top down so the lowest-indexed requester is written last
  always_comb begin
    gnt_o = '0;
    id_o  = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        gnt_o    = '0;
        gnt_o[i] = 1'b1;
        id_o     = ID_W'(i);
      end
    end
    any_o = |req_i;
  end

endmodule
`default_nettype wire

// File: rtl/rr_grant_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : rr_grant_scheduler
// Description : Round-robin grant scheduler with bounded hold time. One owner
//               at a time, a mandatory idle cycle between grants, and a
//               timeout pulse when a grant is force-released.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_grant_scheduler
  import rr_sched_pkg::*;
#(
  parameter int unsigned NUM_PORTS = c_NUM_PORTS_DEFAULT,
  parameter int unsigned MAX_HOLD  = c_MAX_HOLD_DEFAULT
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_PORTS-1:0]         req_i,
  input  logic                         done_i,
  output logic [NUM_PORTS-1:0]         gnt_o,
  output logic [$clog2(NUM_PORTS)-1:0] gnt_id_o,
  output logic                         busy_o,
  output logic                         timeout_o
);

  localparam int unsigned ID_W  = $clog2(NUM_PORTS);
  localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);

  sched_state_e           state_q, state_d;
  logic [NUM_PORTS-1:0]   mask_q, mask_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_PORTS-1:0]   gnt_q, gnt_d;
  logic [ID_W-1:0]        gnt_id_q, gnt_id_d;
  logic                   busy_q, busy_d;
  logic                   timeout_q, timeout_d;

  logic [NUM_PORTS-1:0]   masked_gnt, raw_gnt;
  logic [ID_W-1:0]        masked_id, raw_id;
  logic                   masked_any, raw_any;
  logic                   owner_req, hold_last, normal_rel;

  // Preferred winner among ports above the last owner
  fixed_priority_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb_masked (
    .req_i (req_i & mask_q),
    .gnt_o (masked_gnt),
    .id_o  (masked_id),
    .any_o (masked_any)
  );

  // Fallback winner (wrap-around) when nobody above the last owner requests
  fixed_priority_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb_raw (
    .req_i (req_i),
    .gnt_o (raw_gnt),
    .id_o  (raw_id),
    .any_o (raw_any)
  );

  assign owner_req  = req_i[gnt_id_q];
  assign hold_last  = (cnt_q == CNT_W'(MAX_HOLD - 1));
  assign normal_rel = done_i || !owner_req;

  // Next-state: arbitrate in IDLE, track hold time and release in BUSY
  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (raw_any) begin
          state_d  = BUSY;
          busy_d   = 1'b1;
          cnt_d    = '0;
          gnt_d    = masked_any ? masked_gnt : raw_gnt;
          gnt_id_d = masked_any ? masked_id  : raw_id;
        end
      end
      BUSY: begin
        if (normal_rel || hold_last) begin
          state_d   = IDLE;
          busy_d    = 1'b0;
          gnt_d     = '0;
          gnt_id_d  = '0;
          cnt_d     = '0;
          // A simultaneous normal release takes precedence over the timeout
          timeout_d = !normal_rel;
          // Next round favours the ports strictly above the releasing owner
          for (int i = 0; i < NUM_PORTS; i++) begin
            mask_d[i] = (i > int'(gnt_id_q));
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d  = IDLE;
        busy_d   = 1'b0;
        gnt_d    = '0;
        gnt_id_d = '0;
        cnt_d    = '0;
      end
    endcase
  end

  // State and output registers with asynchronous reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      mask_q    <= '1;
      cnt_q     <= '0;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign gnt_id_o  = gnt_id_q;
  assign busy_o    = busy_q;
  assign timeout_o = timeout_q;

endmodule
`default_nettype wire

// File: doc/rr_grant_scheduler.md
RR_GRANT_SCHEDULER -- requirements
Module: rr_grant_scheduler

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4, meaning the number of requesters (minimum 2).
REQ-002 SHALL have parameter MAX_HOLD, default 8, meaning the maximum number of cycles one grant is held (minimum 1).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port req_i  input  NUM_PORTS  request per port; level-sensitive; a requester holds it until it is served.
REQ-006 SHALL have port done_i  input  1  the current owner releases the resource; sampled only in BUSY.
REQ-007 SHALL have port gnt_o  output  NUM_PORTS  registered one-hot grant; all zeros when no port owns the resource.
REQ-008 SHALL have port gnt_id_o  output  $clog2(NUM_PORTS)  binary index of the owner; valid only while busy_o=1, 0 otherwise.
REQ-009 SHALL have port busy_o  output  1  high while any grant is active.
REQ-010 SHALL have port timeout_o  output  1  one-cycle pulse when a grant is force-released at MAX_HOLD.

Function
REQ-011 SHALL implement a two-state FSM: IDLE (no owner) and BUSY (one owner).
REQ-012 In IDLE with req_i!=0, SHALL select the winner and enter BUSY; gnt_o is asserted in the cycle after req_i is first sampled (1-cycle latency).
REQ-013 In IDLE with req_i==0, SHALL remain in IDLE with gnt_o=0.
REQ-014 Winner selection SHALL be round-robin: a priority mask enables ports strictly above the last owner; the lowest-indexed requester under the mask wins; if no masked requester exists, the lowest-indexed unmasked requester wins.
REQ-015 After reset the mask SHALL be all ones, so port 0 has highest priority.
REQ-016 In BUSY a hold counter SHALL start at 0 in the first grant cycle and increment each BUSY cycle; its width is $clog2(MAX_HOLD+1).
REQ-017 BUSY SHALL release to IDLE when done_i=1, when req_i[owner]=0, or when the counter equals MAX_HOLD-1, whichever occurs first.
REQ-018 On release SHALL drive gnt_o=0 in the following cycle (one mandatory IDLE gap cycle) and update the mask to ports owner+1..NUM_PORTS-1.
REQ-019 timeout_o SHALL pulse in the first IDLE cycle after a release caused only by the counter reaching MAX_HOLD-1.
REQ-020 If done_i=1 or req_i[owner]=0 in the same cycle the counter reaches MAX_HOLD-1, the release SHALL count as normal and timeout_o SHALL stay 0.
REQ-021 When owner=NUM_PORTS-1 releases, the mask SHALL become all zeros, so the fallback path selects the lowest requester (wrap-around).
REQ-022 Changes to req_i on non-owner ports during BUSY SHALL NOT affect gnt_o.
REQ-023 With MAX_HOLD=1, each grant SHALL last exactly one cycle.
REQ-024 gnt_o SHALL always be one-hot or zero, and gnt_id_o SHALL match the set bit of gnt_o.

Reset
REQ-025 On reset_n=0, SHALL immediately and asynchronously force state to IDLE, gnt_o=0, gnt_id_o=0, busy_o=0, timeout_o=0, counter=0, and mask to all ones, including mid-grant.
REQ-026 After reset_n deasserts, the first grant SHALL follow REQ-012 with port 0 at highest priority.

Structure
REQ-027 Package rr_sched_pkg SHALL hold the FSM state enum (IDLE, BUSY) and the default NUM_PORTS and MAX_HOLD constants.
REQ-028 Selection SHALL use two instances of the team's combinational fixed_priority_arbiter sub-module: one on req_i&mask and one on the unmasked req_i.
REQ-029 All outputs SHALL be driven directly from flops.

Verification
REQ-030 Reset, then req_i=4'b1111 held with done_i pulsed each grant -> grants in order 0,1,2,3,0, each separated by one zero-grant cycle.
REQ-031 req_i=4'b0100 with done_i=0 held, MAX_HOLD=8 -> gnt_o=4'b0100 for exactly 8 cycles, then gnt_o=0 with timeout_o=1 for one cycle.
REQ-032 Owner is port 3 and req_i=4'b1001; release -> next grant goes to port 0 (wrap).
REQ-033 Port 1 owns and drops req_i[1] at hold count 2 -> gnt_o=0 next cycle, timeout_o=0.
REQ-034 done_i=1 exactly at hold count 7 -> release with timeout_o=0.
REQ-035 Assert reset_n=0 while port 2 is in BUSY -> gnt_o=0 immediately; after release of reset with req_i=4'b0110, port 1 is granted first.
